// File: rtl/ntt_pkg.sv
// Shared constants, types and modular-arithmetic helpers for the Kyber NTT/INTT blocks.
package ntt_pkg;

    localparam int unsigned COEFF_W   = 12;
    localparam int unsigned SUM_W     = COEFF_W + 1;
    localparam int unsigned Q         = 3329;
    localparam int unsigned N         = 256;
    localparam int unsigned N_INV     = 3303;
    localparam int unsigned ZETA_N    = 128;
    localparam int unsigned BARRETT_K = 24;
    localparam int unsigned BARRETT_M = 5039;

    typedef logic [COEFF_W-1:0] coeff_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_BFLY,
        ST_SCALE,
        ST_DONE
    } state_e;

    function automatic logic [6:0] brv7(input logic [6:0] x);
        logic [6:0] r;
        logic [6:0] v;
        r = '0;
        v = x;
        for (int i = 0; i < 7; i++) begin
            r = {r[5:0], v[0]};
            v = v >> 1;
        end
        return r;
    endfunction

    // 17 is a primitive 256th root of unity, so 17^-e = -17^(128-e) for e in 1..127.
    function automatic logic [ZETA_N-1:0][COEFF_W-1:0] gen_zeta_inv();
        logic [ZETA_N-1:0][COEFF_W-1:0] pw;
        logic [ZETA_N-1:0][COEFF_W-1:0] tab;
        logic [6:0]                     e;
        int unsigned                    acc;
        acc = 1;
        for (int i = 0; i < 128; i++) begin
            pw[7'(i)] = COEFF_W'(acc);
            acc = (acc * 17) % Q;
        end
        for (int k = 0; k < 128; k++) begin
            e = brv7(7'(k));
            if (e == 7'd0) begin
                tab[7'(k)] = COEFF_W'(1);
            end else begin
                tab[7'(k)] = COEFF_W'(Q - 32'(pw[7'd0 - e]));
            end
        end
        return tab;
    endfunction

    localparam logic [ZETA_N-1:0][COEFF_W-1:0] ZETA_INV = gen_zeta_inv();

    // Barrett: quotient estimate is low by at most one, so one conditional subtract suffices.
    function automatic coeff_t barrett_mul(input coeff_t a, input coeff_t b);
        logic [23:0] prod;
        logic [36:0] est;
        logic [11:0] quot;
        logic [24:0] rem;
        prod = 24'(a) * 24'(b);
        est  = 37'(prod) * 37'(BARRETT_M);
        quot = 12'(est >> BARRETT_K);
        rem  = 25'(prod) - 25'(quot) * 25'(Q);
        if (rem >= 25'(Q)) begin
            rem = rem - 25'(Q);
        end
        return COEFF_W'(rem);
    endfunction

endpackage

// File: rtl/intt_bfly.sv
// Combinational Gentleman-Sande butterfly: a' = a+b, b' = w*(a-b), all mod Q.
module intt_bfly
    import ntt_pkg::*;
(
    input  coeff_t a_i,
    input  coeff_t b_i,
    input  coeff_t w_i,
    output coeff_t a_c_o,
    output coeff_t b_c_o
);

    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] diff;

    always_comb begin
        sum = {1'b0, a_i} + {1'b0, b_i};
        if (sum >= SUM_W'(Q)) begin
            sum = sum - SUM_W'(Q);
        end
        if (a_i >= b_i) begin
            diff = {1'b0, a_i} - {1'b0, b_i};
        end else begin
            diff = {1'b0, a_i} + SUM_W'(Q) - {1'b0, b_i};
        end
        a_c_o = COEFF_W'(sum);
        b_c_o = barrett_mul(w_i, COEFF_W'(diff));
    end

endmodule

// File: rtl/intt.sv
// Iterative inverse NTT over Z_q[X]/(X^256+1): 7 GS layers, one butterfly per cycle,
// then a 2-coefficient-per-cycle scaling pass by 128^-1 mod q.
module intt
    import ntt_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   start_i,
    input  coeff_t coeff_i [0:N-1],
    output coeff_t coeff_o [0:N-1],
    output logic   busy_o,
    output logic   done_o
);

    localparam int unsigned LAYER_W = 3;
    localparam int unsigned CNT_W   = 7;
    localparam int unsigned IDX_W   = 8;

    state_e             state_q, state_d;
    logic [LAYER_W-1:0] layer_q, layer_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    coeff_t             r_q   [0:N-1];
    coeff_t             r_d   [0:N-1];
    coeff_t             out_q [0:N-1];
    coeff_t             out_d [0:N-1];
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [3:0]         sh;
    logic [IDX_W-1:0]   len;
    logic [CNT_W-1:0]   blk;
    logic [CNT_W-1:0]   k;
    logic [IDX_W-1:0]   idx_a, idx_b, idx_lo, idx_hi;
    coeff_t             op_a, op_b, w;
    coeff_t             bf_a, bf_b;
    coeff_t             sc_lo, sc_hi;

    // Butterfly / scaling operand addressing from the layer and butterfly counters.
    always_comb begin
        sh     = 4'(layer_q) + 4'd1;
        len    = 8'd1 << sh;
        blk    = cnt_q >> sh;
        idx_a  = (8'(blk) << (sh + 4'd1)) | (8'(cnt_q) & (len - 8'd1));
        idx_b  = idx_a + len;
        k      = 7'((8'd128 >> sh) + 8'(blk));
        w      = ZETA_INV[k];
        op_a   = r_q[idx_a];
        op_b   = r_q[idx_b];
        idx_lo = {cnt_q, 1'b0};
        idx_hi = {cnt_q, 1'b1};
        sc_lo  = barrett_mul(r_q[idx_lo], COEFF_W'(N_INV));
        sc_hi  = barrett_mul(r_q[idx_hi], COEFF_W'(N_INV));
    end

    intt_bfly u_bfly (
        .a_i   (op_a),
        .b_i   (op_b),
        .w_i   (w),
        .a_c_o (bf_a),
        .b_c_o (bf_b)
    );

    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        out_d   = out_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d = ST_LOAD;
                    r_d     = coeff_i;
                    layer_d = '0;
                    cnt_d   = '0;
                end
            end
            ST_LOAD: begin
                state_d = ST_BFLY;
            end
            ST_BFLY: begin
                r_d[idx_a] = bf_a;
                r_d[idx_b] = bf_b;
                cnt_d      = cnt_q + 7'd1;
                if (cnt_q == 7'd127) begin
                    if (layer_q == 3'd6) begin
                        layer_d = '0;
                        state_d = ST_SCALE;
                    end else begin
                        layer_d = layer_q + 3'd1;
                    end
                end
            end
            ST_SCALE: begin
                r_d[idx_lo] = sc_lo;
                r_d[idx_hi] = sc_hi;
                cnt_d       = cnt_q + 7'd1;
                // Publish including the final pair scaled on this same edge.
                if (cnt_q == 7'd127) begin
                    state_d = ST_DONE;
                    out_d   = r_d;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_LOAD) || (state_d == ST_BFLY) || (state_d == ST_SCALE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            layer_q <= '0;
            cnt_q   <= '0;
            r_q     <= '{default: '0};
            out_q   <= '{default: '0};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign coeff_o = out_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule

// File: doc/intt.md
Name: intt

Overview:
- Inverse NTT for the Kyber-style ring Z_q[X]/(X^256+1), with q=3329.
- Companion of the forward ntt block. It takes 256 NTT-domain coefficients and returns the normal-domain polynomial, scaled so that intt(ntt(a)) = a exactly.
- Uses an iterative Gentleman-Sande datapath: 7 layers, one butterfly per cycle, then a final scaling pass by 128^-1 mod q.
- Has the same array-in/array-out, start/done interface as ntt, so the two can be chained.

Parameters:
- COEFF_W, 12, coefficient width in bits.
- Q, 3329, modulus.
- N_INV, 3303, 128^-1 mod Q (128*3303 = 1 mod 3329).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- start_i  input  1  request; coeff_i is sampled on the edge where start_i=1 and the block is not busy.
- coeff_i  input  12 x [0:255]  NTT-domain coefficients; must be canonical (< Q).
- coeff_o  output  12 x [0:255]  result; valid while done_o=1.
- busy_o  output  1  high from the accept edge until done.
- done_o  output  1  level; high after completion until the next accepted start or reset.

Behaviour:
- Clock/reset (already decided): one clock, clk_i; reset rst_ni is asynchronous and active-low.
- Reset values: state=IDLE, coeff_o all 0, busy_o=0, done_o=0, all counters 0.
- FSM states:
  - IDLE/DONE to LOAD: on start_i=1.
  - LOAD to BFLY: copy coeff_i into the working register file. Takes 1 cycle; clears done_o and sets busy_o.
  - BFLY to SCALE: after 896 cycles.
  - SCALE to DONE: after 128 cycles.
  - DONE: hold; done_o=1, busy_o=0.
- BFLY scheduling:
  - Layer counter L = 0..6 gives len = 2<<L (2, 4, ..., 128).
  - Butterfly counter c = 0..127 gives block = c / len and j = 2*len*block + (c mod len).
  - Operand pair is (r[j], r[j+len]).
- Twiddle index: k = 128/len + block (len=2 uses k=64..127; len=128 uses k=1). w = ZETA_INV[k] = 17^(-brv7(k)) mod Q.
- GS butterfly, one per cycle, written back on the same edge:
  - a' = (a+b) mod Q
  - b' = w*((a-b) mod Q) mod Q
- SCALE: 2 coefficients per cycle. At cycle s (0..127), r[2s] and r[2s+1] are replaced by r*N_INV mod Q.
- coeff_o is updated from the working register file on the SCALE to DONE transition only. It holds its previous value while busy.
- Arithmetic:
  - Add: 13-bit sum, conditional subtract of Q.
  - Subtract: add Q if the difference is negative.
  - Multiply: 12x12 gives a 24-bit product, reduced by Barrett to [0, Q-1].
  - All results are canonical.
- Latency: exactly 1025 cycles from the start-accept edge to the edge where done_o rises (1 LOAD + 896 BFLY + 128 SCALE).
- start_i while busy_o=1 is ignored; no restart and no effect on the result.
- start_i in DONE restarts the operation. done_o falls on the accept edge.
- start_i held high after completion retriggers immediately. This is legal and behaves as back-to-back operations.
- Reset mid-operation aborts: the state returns to IDLE and all outputs take their reset values.
- Non-canonical inputs are outside the contract; the bench must not drive them.

Decomposition:
- Shared package ntt_pkg:
  - Q, N=256, N_INV, COEFF_W
  - coeff_t typedef (logic [11:0])
  - 128-entry ZETA_INV constant table
  - FSM state enum
  - the forward ZETA table, if ntt shares the package
- Sub-module intt_bfly: combinational GS butterfly with inputs (a, b, w) and outputs (a', b'), built around a barrett_mul helper function defined in the package.
- The top level holds the FSM, counters, index generation and register file. Estimated 200-300 lines.

Test Plan:
1. All-zero input with start pulsed 1 cycle -> coeff_o all 0; done_o rises exactly 1025 cycles after accept; busy_o high for cycles 1..1024.
2. Input coeff_i[2i]=1, coeff_i[2i+1]=0 for all i (NTT of constant 1) -> coeff_o[0]=1, all other indices 0.
3. Round trip: random canonical sample file -> ntt -> intt (chained by done_o to start_i) -> output equals the sample file at all 256 indices. Run 50 random seeds against a golden model.
4. Start re-asserted at cycles 10 and 500 of a run -> result and done timing identical to scenario 3, with no restart.
5. rst_ni dropped at cycle 400 -> done_o=0, busy_o=0, coeff_o all 0 immediately (async). A fresh start then gives the correct result after 1025 cycles.
6. Back-to-back: start held high with two different inputs -> two correct results. done_o drops for 1025 cycles between them; coeff_o is stable during the second run until done_o rises.
